// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: MemRW codes, access sizes, FSM states and op-decode helpers shared with the control decoder
package mem_access_unit_pkg;

    localparam logic [3:0] MRW_SB  = 4'b1000;
    localparam logic [3:0] MRW_SH  = 4'b1001;
    localparam logic [3:0] MRW_SW  = 4'b1010;
    localparam logic [3:0] MRW_LB  = 4'b1011;
    localparam logic [3:0] MRW_LBU = 4'b1100;
    localparam logic [3:0] MRW_LH  = 4'b1101;
    localparam logic [3:0] MRW_LHU = 4'b1110;
    localparam logic [3:0] MRW_LW  = 4'b1111;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic size_e op_size(input logic [2:0] op);
        return (op == MRW_LW[2:0] || op == MRW_SW[2:0]) ? SZ_W :
               (op == MRW_LH[2:0] || op == MRW_LHU[2:0] || op == MRW_SH[2:0]) ? SZ_H : SZ_B;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return op == MRW_LB[2:0] || op == MRW_LH[2:0];
    endfunction

    // 000/001/010 are stores; every other code reads memory
    function automatic logic op_is_load(input logic [2:0] op);
        return op != MRW_SB[2:0] && op != MRW_SH[2:0] && op != MRW_SW[2:0];
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        return (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide byte-enabled request/ack data bus
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata driven by the master,
//   bus_ack/bus_rdata driven by the slave (rdata valid in the ack cycle)
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    modport master(output bus_req, bus_we, bus_be, bus_addr, bus_wdata, input bus_ack, bus_rdata);
    modport slave(input bus_req, bus_we, bus_be, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one access
//   op        in  3   MemRW[2:0] code
//   addr_lo   in  2   address byte offset
//   wdata     in  32  unshifted store data
//   rdata     in  32  read word from the bus
//   be        out 4   byte enables, bit i = lane i
//   wdata_rep out 32  store data replicated into every lane
//   rdata_ext out 32  selected lane, sign/zero extended
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    size_e       sz;
    logic        sgn;
    logic [31:0] lane;
    always_comb begin
        sz        = op_size(op);
        sgn       = op_signed(op);
        lane      = rdata >> {addr_lo, 3'b000};
        be        = sz == SZ_W ? 4'b1111 : sz == SZ_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_lo;
        wdata_rep = sz == SZ_W ? wdata : sz == SZ_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        rdata_ext = sz == SZ_W ? lane :
                    sz == SZ_H ? {{16{sgn & lane[15]}}, lane[15:0]} : {{24{sgn & lane[7]}}, lane[7:0]};
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage MemRW consumer driving a request/ack bus with pipeline stall
//   clk, rst   clock and synchronous active-high reset
//   mem_rw     4-bit MemRW code ([3] = access), addr/wdata from EX/MEM
//   stall      freeze IF..MEM while an access is accepted or in flight
//   load_data  extended load result, valid with the load_done pulse
//   misalign   pulse: misaligned access rejected without a bus op
//   bus_err    pulse: no ack within TIMEOUT cycles
//   bus        master side of mem_access_unit_if
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_rw,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_done,
    output logic              misalign,
    output logic              bus_err,
    mem_access_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_q, err_d;
    logic        misalign_q, misalign_d;
    logic        bad, accept, busy;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_ext;

    mem_lane_align u_align (
        .op(op_q),
        .addr_lo(addr_q[1:0]),
        .wdata(wdata_q),
        .rdata(bus.bus_rdata),
        .be(be),
        .wdata_rep(wdata_rep),
        .rdata_ext(rdata_ext)
    );

    assign bad       = misaligned(op_size(mem_rw[2:0]), addr[1:0]);
    assign accept    = state_q == IDLE && mem_rw[3] && !bad;
    assign busy      = state_q == BUSY;
    // the accept cycle stalls combinationally so EX/MEM keeps the instruction
    assign stall     = !rst && (busy || accept);
    assign load_data = load_data_q;
    assign load_done = state_q == DONE && op_is_load(op_q);
    assign misalign  = misalign_q;
    assign bus_err   = err_q;

    assign bus.bus_req   = busy;
    assign bus.bus_we    = busy && !op_is_load(op_q);
    assign bus.bus_be    = busy ? be : 4'b0000;
    assign bus.bus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.bus_wdata = busy ? wdata_rep : 32'd0;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_d       = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            IDLE: begin
                misalign_d = mem_rw[3] && bad;
                if (accept) begin
                    state_d = BUSY;
                    op_d    = mem_rw[2:0];
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (bus.bus_ack) begin
                    state_d     = DONE;
                    load_data_d = rdata_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    load_data_d = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            misalign_q  <= misalign_d;
        end
    end
endmodule
